// File: rtl/baud_pkg.sv
// Shared constants and types for the fractional UART baud-rate generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   MIN_INT              smallest integer divisor that is ever applied
//   DEF_INT_W/FRAC_W     default divisor field widths
//   DEF_INT_DIV/FRAC_DIV reset divisor (100 MHz core, 9600 baud, 16x oversample)
//   baud_cfg_t           divisor record as seen by software / config sources
package baud_pkg;

  // A period of 1 would give back-to-back ticks and break the
  // "one sample tick per period" contract downstream.
  localparam int MIN_INT = 2;

  localparam int DEF_INT_W  = 16;
  localparam int DEF_FRAC_W = 4;

  localparam int DEF_INT_DIV  = 651;
  localparam int DEF_FRAC_DIV = 1;

  // Field 'int' is a reserved word in SystemVerilog, hence int_div.
  typedef struct packed {
    logic [DEF_INT_W-1:0]  int_div;
    logic [DEF_FRAC_W-1:0] frac;
  } baud_cfg_t;

endpackage

// File: rtl/baud_gen_frac_divider.sv
// Fractional period divider: emits one sample_tick every act_int or act_int+1 cycles.
// Latency: tick is combinational from cnt/acc; first tick limit cycles after restart.
// Backpressure: none; enable low freezes cnt/acc and suppresses the tick.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   enable              count enable (ignored while restart is high)
//   restart             synchronous phase restart: cnt and acc go to 0
//   act_int, act_frac   active divisor (period = act_int + act_frac/2^FRAC_W)
//   sample_tick         1-cycle tick on the last cycle of each period
module frac_divider
  import baud_pkg::*;
#(
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  input  logic [INT_W-1:0]  act_int,
  input  logic [FRAC_W-1:0] act_frac,
  output logic              sample_tick
);

  logic [INT_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   frac_sum;
  logic              carry;
  logic [INT_W:0]    limit;
  logic [INT_W:0]    last;
  logic              at_last;

  // The accumulator overflow of the period now in progress decides whether
  // this period is stretched by one cycle.
  assign frac_sum = {1'b0, acc} + {1'b0, act_frac};
  assign carry    = frac_sum[FRAC_W];

  // One extra bit so act_int = all-ones plus a carry does not wrap.
  assign limit   = {1'b0, act_int} + {{INT_W{1'b0}}, carry};
  assign last    = limit - {{INT_W{1'b0}}, 1'b1};
  assign at_last = ({1'b0, cnt} == last);

  assign sample_tick = enable && !restart && at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
    end else if (restart) begin
      cnt <= '0;
      acc <= '0;
    end else if (enable) begin
      if (at_last) begin
        cnt <= '0;
        acc <= frac_sum[FRAC_W-1:0];
      end else begin
        cnt <= cnt + INT_W'(1);
      end
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: sample/bit/mid-bit ticks with runtime-programmable divisor.
// Latency: ticks combinational from state; new divisor takes effect at the next sample tick or restart.
// Backpressure: cfg_ready drops after a divisor is accepted and rises once it has been applied.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   enable                 low: all counters hold, all ticks forced to 0
//   restart                synchronous phase restart (RX start-bit alignment)
//   cfg_valid/cfg_ready    divisor offer / accept handshake
//   cfg_int, cfg_frac      offered divisor; cfg_int below MIN_INT is stored as MIN_INT
//   sample_tick            oversample tick, average period INT + FRAC/2^FRAC_W cycles
//   bit_tick               last sample of each bit (uart_tx)
//   mid_tick               sample OVERSAMPLE/2-1 of each bit (uart_rx)
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int INT_W      = DEF_INT_W,
  parameter int FRAC_W     = DEF_FRAC_W,
  parameter int OVERSAMPLE = 16,
  parameter int DEF_INT    = DEF_INT_DIV,
  parameter int DEF_FRAC   = DEF_FRAC_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  input  logic              cfg_valid,
  input  logic [INT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_ready,
  output logic              sample_tick,
  output logic              bit_tick,
  output logic              mid_tick
);

  localparam int                OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]   OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]   OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [INT_W-1:0]  INT_MIN = INT_W'(MIN_INT);

  logic [INT_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [INT_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;
  logic              pend;
  logic [INT_W-1:0]  cfg_int_clamped;
  logic              cfg_xfer;
  logic              apply;
  logic [OS_W-1:0]   os;

  assign cfg_ready       = !pend;
  assign cfg_xfer        = cfg_valid && cfg_ready;
  assign cfg_int_clamped = (cfg_int < INT_MIN) ? INT_MIN : cfg_int;

  // Swap happens on the edge that closes a period, so that period still runs
  // on the old divisor. A restart swaps immediately since the phase is
  // being thrown away anyway. sample_tick is already low during restart.
  assign apply = pend && (restart || sample_tick);

  frac_divider #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .restart     (restart),
    .act_int     (act_int),
    .act_frac    (act_frac),
    .sample_tick (sample_tick)
  );

  // Transfer and apply are mutually exclusive: transfer needs pend=0,
  // apply needs pend=1. A transfer on a tick cycle therefore waits for
  // the following tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_int  <= INT_W'(DEF_INT);
      act_frac <= FRAC_W'(DEF_FRAC);
      sh_int   <= '0;
      sh_frac  <= '0;
      pend     <= 1'b0;
    end else if (cfg_xfer) begin
      sh_int   <= cfg_int_clamped;
      sh_frac  <= cfg_frac;
      pend     <= 1'b1;
    end else if (apply) begin
      act_int  <= sh_int;
      act_frac <= sh_frac;
      pend     <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os <= '0;
    end else if (restart) begin
      os <= '0;
    end else if (sample_tick) begin
      os <= (os == OS_LAST) ? '0 : os + OS_W'(1);
    end
  end

  assign bit_tick = sample_tick && (os == OS_LAST);
  assign mid_tick = sample_tick && (os == OS_MID);

endmodule

// File: tb/tb_baud_gen_frac.sv
module tb_baud_gen_frac;
  import baud_pkg::*;

  localparam int INT_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OS     = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              restart;
  logic              cfg_valid;
  logic [INT_W-1:0]  cfg_int;
  logic [FRAC_W-1:0] cfg_frac;
  logic              cfg_ready;
  logic              sample_tick;
  logic              bit_tick;
  logic              mid_tick;

  always #5 clk = ~clk;

  baud_gen_frac #(
    .INT_W      (INT_W),
    .FRAC_W     (FRAC_W),
    .OVERSAMPLE (OS),
    .DEF_INT    (651),
    .DEF_FRAC   (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .restart     (restart),
    .cfg_valid   (cfg_valid),
    .cfg_int     (cfg_int),
    .cfg_frac    (cfg_frac),
    .cfg_ready   (cfg_ready),
    .sample_tick (sample_tick),
    .bit_tick    (bit_tick),
    .mid_tick    (mid_tick)
  );

  int vecs  = 0;
  int fails = 0;

  // Divisor, cycles for 16 ticks after a restart, cycle of the 8th tick (mid_tick).
  typedef struct {
    baud_cfg_t cfg;
    int        total;
    int        mid;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from the current one up to and including the next
  // sample_tick cycle; returns just after the edge that closes it.
  task automatic next_tick(output int n, output logic bt, output logic mt);
    logic got;
    n   = 0;
    got = 1'b0;
    bt  = 1'b0;
    mt  = 1'b0;
    while (!got && n < 6000) begin
      n++;
      @(negedge clk);
      got = sample_tick;
      bt  = bit_tick;
      mt  = mid_tick;
      @(posedge clk);
      #1;
    end
  endtask

  // Releases reset and counts edges up to and including the one that
  // registers the first sample_tick.
  task automatic release_and_count(output int edges);
    logic got;
    edges = 0;
    got   = 1'b0;
    reset = 1'b0;
    while (!got && edges < 2000) begin
      @(negedge clk);
      got = sample_tick;
      @(posedge clk);
      edges++;
    end
    #1;
  endtask

  // Offers a divisor, then restarts so it applies at once. Returns in
  // cycle 1 of the fresh phase (cnt=0, acc=0, os=0).
  task automatic program_div(input int iv, input int fv);
    cfg_int   = INT_W'(iv);
    cfg_frac  = FRAC_W'(fv);
    cfg_valid = 1'b1;
    #1 chk("ready_idle", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    restart   = 1'b1;
    #1;
    chk("ready_pending", cfg_ready, 0);
    chk("restart_quiet", sample_tick, 0);
    step();
    restart = 1'b0;
    #1 chk("ready_applied", cfg_ready, 1);
  endtask

  initial begin
    int   n, edges, total, mid_c, bit_c, mid_idx, bit_idx, seen;
    logic bt, mt;

    tbl[0] = '{cfg: {16'd4,   4'd0},  total: 64,   mid: 32};
    tbl[1] = '{cfg: {16'd4,   4'd8},  total: 72,   mid: 36};
    tbl[2] = '{cfg: {16'd5,   4'd3},  total: 83,   mid: 41};
    tbl[3] = '{cfg: {16'd1,   4'd0},  total: 32,   mid: 16};
    tbl[4] = '{cfg: {16'd0,   4'd5},  total: 37,   mid: 18};
    tbl[5] = '{cfg: {16'd2,   4'd15}, total: 47,   mid: 23};
    tbl[6] = '{cfg: {16'd300, 4'd1},  total: 4801, mid: 2400};

    reset     = 1'b1;
    enable    = 1'b0;
    restart   = 1'b0;
    cfg_valid = 1'b0;
    cfg_int   = '0;
    cfg_frac  = '0;

    // Reset state.
    step();
    chk("rst_sample", sample_tick, 0);
    chk("rst_bit", bit_tick, 0);
    chk("rst_mid", mid_tick, 0);
    chk("rst_ready", cfg_ready, 1);

    // Default divisor 651+1/16: acc starts at 0, so the first period is 651.
    enable = 1'b1;
    release_and_count(edges);
    chk("reset_latency", edges, 651);

    // Table: rate, fractional pattern, clamping, bit/mid tick placement.
    for (int i = 0; i < 7; i++) begin
      program_div(int'(tbl[i].cfg.int_div), int'(tbl[i].cfg.frac));
      total = 0;
      mid_c = 0;
      bit_c = 0;
      for (int k = 0; k < 16; k++) begin
        next_tick(n, bt, mt);
        total += n;
        if (mt && mid_c == 0) mid_c = total;
        if (bt && bit_c == 0) bit_c = total;
      end
      chk($sformatf("vec%0d_total", i), total, tbl[i].total);
      chk($sformatf("vec%0d_mid", i), mid_c, tbl[i].mid);
      chk($sformatf("vec%0d_bit", i), bit_c, tbl[i].total);
    end

    // Reprogram to 6 two cycles into a 4-cycle period.
    program_div(4, 0);
    step();
    cfg_int   = 16'd6;
    cfg_frac  = 4'd0;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    #1 chk("midcfg_ready_low", cfg_ready, 0);
    next_tick(n, bt, mt);
    chk("midcfg_old_period_end", n, 2);
    #1 chk("midcfg_ready_high", cfg_ready, 1);
    next_tick(n, bt, mt);
    chk("midcfg_new_period", n, 6);

    // Restart with os=9 and acc=8 on the cycle a tick was due.
    program_div(4, 8);
    next_tick(n, bt, mt);
    chk("frac_period_a", n, 4);
    next_tick(n, bt, mt);
    chk("frac_period_b", n, 5);
    for (int k = 0; k < 7; k++) next_tick(n, bt, mt);
    for (int k = 0; k < 4; k++) step();
    #1 chk("restart_tick_due", sample_tick, 1);
    restart = 1'b1;
    #1 chk("restart_suppresses_tick", sample_tick, 0);
    step();
    restart = 1'b0;
    next_tick(n, bt, mt);
    chk("restart_first_period", n, 4);
    mid_idx = mt ? 1 : 0;
    bit_idx = bt ? 1 : 0;
    for (int k = 2; k <= 20 && bit_idx == 0; k++) begin
      next_tick(n, bt, mt);
      if (mt && mid_idx == 0) mid_idx = k;
      if (bt) bit_idx = k;
    end
    chk("restart_mid_index", mid_idx, 8);
    chk("restart_bit_index", bit_idx, 16);

    // Enable low for 10 cycles with cnt sitting on limit-1.
    program_div(5, 0);
    for (int k = 0; k < 4; k++) step();
    enable = 1'b0;
    seen   = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sample_tick || bit_tick || mid_tick) seen++;
      step();
    end
    chk("disabled_ticks", seen, 0);
    enable = 1'b1;
    next_tick(n, bt, mt);
    chk("resume_remaining", n, 1);
    next_tick(n, bt, mt);
    chk("resume_next_period", n, 5);

    // Transfer on a tick cycle, then async reset with pend=1.
    program_div(4, 0);
    for (int k = 0; k < 3; k++) step();
    cfg_int   = 16'd9;
    cfg_frac  = 4'd0;
    cfg_valid = 1'b1;
    #1 chk("xfer_on_tick", sample_tick, 1);
    step();
    cfg_valid = 1'b0;
    #1 chk("xfer_on_tick_ready", cfg_ready, 0);
    for (int k = 0; k < 3; k++) step();
    #1;
    chk("old_div_kept", sample_tick, 1);
    chk("still_pending", cfg_ready, 0);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_sample", sample_tick, 0);
    chk("async_rst_bit", bit_tick, 0);
    chk("async_rst_mid", mid_tick, 0);
    chk("async_rst_ready", cfg_ready, 1);
    release_and_count(edges);
    chk("reset_restores_default", edges, 651);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
